// File: rtl/bus_mux_encoder.sv
// Registered one-hot bus multiplexer with priority encoding.
// Multi-hot selects resolve to the lowest source and are logged as conflicts.
module bus_mux_encoder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_SRC    = 24,
    parameter logic [DATA_WIDTH-1:0] INIT       = 32'h0
) (
    input  logic                            clock,
    input  logic                            clear,
    input  logic                            enable,
    input  logic [NUM_SRC-1:0]              src_out,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   BusMuxIn_flat,
    output logic [DATA_WIDTH-1:0]           BusMuxOut,
    output logic                            bus_valid,
    output logic [4:0]                      sel_code,
    output logic                            conflict,
    output logic [7:0]                      conflict_count
);

    typedef enum logic [1:0] {
        POP_ZERO,
        POP_ONE,
        POP_MANY
    } pop_t;

    localparam logic [NUM_SRC-1:0] ONE = {{(NUM_SRC-1){1'b0}}, 1'b1};

    logic [4:0]            idx;
    logic [DATA_WIDTH-1:0] word;
    logic                  none_set;
    logic                  multi_set;
    pop_t                  pop;

    // Scan from the top so the lowest set bit is the one that sticks.
    always_comb begin
        idx  = '0;
        word = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_out[i]) begin
                idx  = i[4:0];
                word = BusMuxIn_flat[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    assign none_set  = ~|src_out;
    assign multi_set = |(src_out & (src_out - ONE));

    always_comb begin
        pop = POP_ONE;
        unique case (1'b1)
            none_set:  pop = POP_ZERO;
            multi_set: pop = POP_MANY;
            default:   pop = POP_ONE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            BusMuxOut      <= INIT;
            bus_valid      <= 1'b0;
            sel_code       <= 5'd0;
            conflict       <= 1'b0;
            conflict_count <= 8'd0;
        end else begin
            bus_valid <= 1'b0;
            if (enable && pop != POP_ZERO) begin
                BusMuxOut <= word;
                sel_code  <= idx;
                bus_valid <= 1'b1;
                if (pop == POP_MANY) begin
                    conflict <= 1'b1;
                    if (conflict_count != 8'hFF)
                        conflict_count <= conflict_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_mux_encoder.sv
// Directed-vector bench for bus_mux_encoder.
// Vector table plus hand sequences for saturation and async clear.
module tb_bus_mux_encoder;

    localparam int DW = 32;
    localparam int NS = 24;

    logic              clock;
    logic              clear;
    logic              enable;
    logic [NS-1:0]     src_out;
    logic [NS*DW-1:0]  BusMuxIn_flat;
    logic [DW-1:0]     BusMuxOut;
    logic              bus_valid;
    logic [4:0]        sel_code;
    logic              conflict;
    logic [7:0]        conflict_count;

    logic [DW-1:0]     mem [NS];

    int total = 0;
    int bad   = 0;

    bus_mux_encoder #(
        .DATA_WIDTH(DW),
        .NUM_SRC   (NS),
        .INIT      (32'h0)
    ) dut (
        .clock         (clock),
        .clear         (clear),
        .enable        (enable),
        .src_out       (src_out),
        .BusMuxIn_flat (BusMuxIn_flat),
        .BusMuxOut     (BusMuxOut),
        .bus_valid     (bus_valid),
        .sel_code      (sel_code),
        .conflict      (conflict),
        .conflict_count(conflict_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        BusMuxIn_flat = '0;
        for (int i = 0; i < NS; i++)
            BusMuxIn_flat[DW*i +: DW] = mem[i];
    end

    typedef struct {
        logic          en;
        logic [23:0]   src;
        logic          wen;
        logic [4:0]    wslot;
        logic [31:0]   wval;
        logic [31:0]   eout;
        logic [4:0]    esel;
        logic          evalid;
        logic          econf;
        logic [7:0]    ecnt;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] eout,
                           input logic [4:0] esel, input logic evalid,
                           input logic econf, input logic [7:0] ecnt);
        chk({tag, ".out"},   BusMuxOut,               eout);
        chk({tag, ".sel"},   32'(sel_code),           32'(esel));
        chk({tag, ".valid"}, 32'(bus_valid),          32'(evalid));
        chk({tag, ".conf"},  32'(conflict),           32'(econf));
        chk({tag, ".cnt"},   32'(conflict_count),     32'(ecnt));
    endtask

    int exp_cnt;

    initial begin
        vecs[0] = '{1'b1, 24'h000020, 1'b1, 5'd5,  32'hDEADBEEF,
                    32'hDEADBEEF, 5'd5,  1'b1, 1'b0, 8'd0};
        vecs[1] = '{1'b1, 24'h000000, 1'b0, 5'd0,  32'h0,
                    32'hDEADBEEF, 5'd5,  1'b0, 1'b0, 8'd0};
        vecs[2] = '{1'b1, 24'h010000, 1'b1, 5'd16, 32'h12345678,
                    32'h12345678, 5'd16, 1'b1, 1'b0, 8'd0};
        vecs[3] = '{1'b0, 24'h800000, 1'b1, 5'd23, 32'h7,
                    32'h12345678, 5'd16, 1'b0, 1'b0, 8'd0};
        vecs[4] = '{1'b1, 24'h800000, 1'b0, 5'd0,  32'h0,
                    32'h7,        5'd23, 1'b1, 1'b0, 8'd0};
        vecs[5] = '{1'b1, 24'h300000, 1'b1, 5'd20, 32'h100,
                    32'h100,      5'd20, 1'b1, 1'b1, 8'd1};
        vecs[6] = '{1'b0, 24'h000003, 1'b0, 5'd0,  32'h0,
                    32'h100,      5'd20, 1'b0, 1'b1, 8'd1};
        vecs[7] = '{1'b1, 24'h000001, 1'b1, 5'd0,  32'h1,
                    32'h1,        5'd0,  1'b1, 1'b1, 8'd1};
        vecs[8] = '{1'b1, 24'hFFFFFF, 1'b0, 5'd0,  32'h0,
                    32'h1,        5'd0,  1'b1, 1'b1, 8'd2};
        vecs[9] = '{1'b1, 24'hC00000, 1'b0, 5'd0,  32'h0,
                    32'hA0000016, 5'd22, 1'b1, 1'b1, 8'd3};

        for (int i = 0; i < NS; i++)
            mem[i] = 32'hA0000000 | 32'(i);
        mem[21] = 32'h200;

        clear   = 1'b1;
        enable  = 1'b0;
        src_out = '0;
        #2;
        chk_all("reset", 32'h0, 5'd0, 1'b0, 1'b0, 8'd0);
        @(negedge clock);
        clear = 1'b0;

        for (int v = 0; v < 10; v++) begin
            @(negedge clock);
            if (vecs[v].wen)
                mem[vecs[v].wslot] = vecs[v].wval;
            enable  = vecs[v].en;
            src_out = vecs[v].src;
            @(posedge clock);
            #1;
            chk_all($sformatf("vec%0d", v), vecs[v].eout, vecs[v].esel,
                    vecs[v].evalid, vecs[v].econf, vecs[v].ecnt);
        end

        exp_cnt = 3;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clock);
            enable  = 1'b1;
            src_out = 24'h000003;
            @(posedge clock);
            #1;
            if (exp_cnt < 255)
                exp_cnt++;
            chk($sformatf("sat%0d.cnt", k), 32'(conflict_count),
                32'(exp_cnt));
        end
        chk("sat.out",  BusMuxOut,        32'h1);
        chk("sat.conf", 32'(conflict),    32'h1);
        chk("sat.ff",   32'(conflict_count), 32'hFF);

        @(negedge clock);
        mem[23]  = 32'h7;
        src_out  = 24'h800000;
        enable   = 1'b1;
        @(posedge clock);
        #3;
        clear = 1'b1;
        #1;
        chk_all("async", 32'h0, 5'd0, 1'b0, 1'b0, 8'd0);
        @(posedge clock);
        #1;
        chk_all("hold_clr", 32'h0, 5'd0, 1'b0, 1'b0, 8'd0);
        @(negedge clock);
        clear   = 1'b0;
        mem[0]  = 32'h1;
        src_out = 24'h000001;
        enable  = 1'b1;
        @(posedge clock);
        #1;
        chk_all("post_clr", 32'h1, 5'd0, 1'b1, 1'b0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
